// File: rtl/dbg_pkg.sv
// Shared codes for the debug memory-access data register.
package dbg_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_BUSY    = 2'b01,
        ST_OVERRUN = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/dbg_dr_shifter.sv
// JTAG-style capture/shift register; bit 0 is the next bit on the wire.
module dbg_dr_shifter #(
    parameter int DR_W = 42
) (
    input  logic            gclk,
    input  logic            grst_n,
    input  logic            capture,
    input  logic            shift,
    input  logic            tdi,
    input  logic [DR_W-1:0] p_data_in,
    output logic [DR_W-1:0] sr,
    output logic            s_data_out
);

    // Capture loads the parallel word; shift moves toward bit 0, TDI enters at the top.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            sr <= '0;
        else if (capture)
            sr <= p_data_in;
        else if (shift)
            sr <= {tdi, sr[DR_W-1:1]};
    end

    assign s_data_out = sr[0];

endmodule

// File: rtl/dbg_mem_dr.sv
// Debug DR that turns an Update-DR command into one single-beat bus access
// and reports read data and sticky status on the next Capture-DR.
module dbg_mem_dr
    import dbg_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              TDI,
    input  logic              shift_dr,
    input  logic              clock_dr,
    input  logic              update_dr,
    output logic              s_data_out_dr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int DR_W  = 2 + ADDR_W + DATA_W;
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter is 0 in the first REQ cycle, so the TIMEOUT-th cycle sees TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state;
    status_e             status;
    status_e             cap_status;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    cnt;
    logic [DR_W-1:0]     sr;
    op_e                 cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;

    assign cmd_op     = op_e'(sr[DR_W-1 -: 2]);
    assign cmd_addr   = sr[DATA_W +: ADDR_W];
    assign cmd_data   = sr[DATA_W-1:0];
    assign cap_status = (state != S_IDLE) ? ST_BUSY : status;

    dbg_dr_shifter #(.DR_W(DR_W)) u_shift (
        .gclk       (TCK),
        .grst_n     (TRST),
        .capture    (clock_dr & ~shift_dr),
        .shift      (clock_dr & shift_dr),
        .tdi        (TDI),
        .p_data_in  ({cap_status, bus_addr, rdata_q}),
        .sr         (sr),
        .s_data_out (s_data_out_dr)
    );

    // Command FSM with timeout counter, registered bus fields and sticky status.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state     <= S_IDLE;
            status    <= ST_OK;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (update_dr) begin
                        case (cmd_op)
                            OP_READ: begin
                                bus_addr <= cmd_addr;
                                bus_we   <= 1'b0;
                                bus_req  <= 1'b1;
                                cnt      <= '0;
                                state    <= S_REQ;
                            end
                            OP_WRITE: begin
                                bus_addr  <= cmd_addr;
                                bus_wdata <= cmd_data;
                                bus_we    <= 1'b1;
                                bus_req   <= 1'b1;
                                cnt       <= '0;
                                state     <= S_REQ;
                            end
                            OP_CLR:  status <= ST_OK;
                            default: ;
                        endcase
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        state   <= S_IDLE;
                        bus_req <= 1'b0;
                        if (status != ST_OVERRUN)
                            status <= ST_OK;
                        if (!bus_we)
                            rdata_q <= bus_rdata;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_IDLE;
                        bus_req <= 1'b0;
                        status  <= ST_TIMEOUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A command arriving while busy is dropped; this outranks any completion on the same edge.
            if (state != S_IDLE && update_dr && cmd_op != OP_NOP)
                status <= ST_OVERRUN;
        end
    end

endmodule

// File: tb/tb_dbg_mem_dr.sv
// Bench for dbg_mem_dr: directed vector table, hand-built corner sequences,
// then random JTAG traffic against a transaction-level model and bus slave.
module tb_dbg_mem_dr;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TO  = 4;
    localparam int DRW = 2 + AW + DW;

    logic          TCK = 1'b0;
    logic          TRST = 1'b1;
    logic          TDI = 1'b0;
    logic          shift_dr = 1'b0;
    logic          clock_dr = 1'b0;
    logic          update_dr = 1'b0;
    logic          s_data_out_dr;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    dbg_mem_dr #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .TCK           (TCK),
        .TRST          (TRST),
        .TDI           (TDI),
        .shift_dr      (shift_dr),
        .clock_dr      (clock_dr),
        .update_dr     (update_dr),
        .s_data_out_dr (s_data_out_dr),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata)
    );

    always #5 TCK = ~TCK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem [256];

    // Model: visible register contents plus the one outstanding transaction.
    logic [1:0]     m_status;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wdata;
    logic [DW-1:0]  m_rdata;
    logic           m_we;
    logic [DRW-1:0] m_sr;
    bit             p_valid;
    bit             p_ok;
    bit             p_read;
    int             p_e, p_end, p_d;
    logic [DW-1:0]  p_val;
    int             force_delay = -1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DRW-1:0] cmd(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
        return {op, a, d};
    endfunction

    function void model_reset();
        m_status = 2'b00; m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0;
        m_sr = '0; p_valid = 0;
    endfunction

    // Retire the outstanding transaction if it finished on or before edge lim.
    function void apply_done(int lim);
        if (p_valid && p_end <= lim) begin
            if (p_ok) begin
                if (m_status != 2'b10) m_status = 2'b00;
                if (p_read) m_rdata = p_val;
            end else begin
                m_status = 2'b11;
            end
            p_valid = 0;
        end
    endfunction

    function automatic logic [DRW-1:0] model_capture(int x);
        apply_done(x - 1);
        return {(p_valid ? 2'b01 : m_status), m_addr, m_rdata};
    endfunction

    function void model_update(int x);
        logic [1:0] op;
        bit busy;
        op = m_sr[DRW-1:DRW-2];
        apply_done(x - 1);
        busy = p_valid;
        apply_done(x);
        if (busy) begin
            if (op != 2'b00) m_status = 2'b10;
        end else if (op == 2'b01 || op == 2'b10) begin
            m_addr = m_sr[DW +: AW];
            m_we   = (op == 2'b10);
            if (op == 2'b10) m_wdata = m_sr[DW-1:0];
            p_d     = (force_delay >= 0) ? force_delay : $urandom_range(0, 6);
            p_valid = 1;
            p_e     = x;
            p_read  = (op == 2'b01);
            p_ok    = (p_d < TO);
            p_end   = p_ok ? x + p_d + 1 : x + TO;
            p_val   = mem[m_addr];
        end else if (op == 2'b11) begin
            m_status = 2'b00;
        end
    endfunction

    // One clock: check the bus outputs after the edge, then act as the bus slave.
    task automatic cycle();
        logic exp_req;
        @(posedge TCK);
        cyc++;
        @(negedge TCK);
        apply_done(cyc);
        exp_req = p_valid && (p_e <= cyc);
        check("bus", {bus_req, bus_we, bus_addr, bus_wdata}, {exp_req, m_we, m_addr, m_wdata});
        if (p_valid && p_ok && cyc == p_e + p_d) begin
            bus_ack   = 1'b1;
            bus_rdata = mem[m_addr];
            if (m_we) mem[m_addr] = m_wdata;
        end else if (p_valid) begin
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
        end else begin
            bus_ack   = ($urandom_range(0, 7) == 0);
            bus_rdata = $urandom;
        end
    endtask

    task automatic do_update();
        update_dr = 1'b1;
        model_update(cyc + 1);
        cycle();
        update_dr = 1'b0;
    endtask

    task automatic scan(input logic [DRW-1:0] din, input bit upd, output logic [DRW-1:0] dout);
        logic [DRW-1:0] exp_cap;
        clock_dr = 1'b1;
        shift_dr = 1'b0;
        exp_cap  = model_capture(cyc + 1);
        cycle();
        for (int i = 0; i < DRW; i++) begin
            dout[i]  = s_data_out_dr;
            shift_dr = 1'b1;
            TDI      = din[i];
            cycle();
        end
        clock_dr = 1'b0;
        shift_dr = 1'b0;
        m_sr     = din;
        check("capture", dout, exp_cap);
        if (upd) do_update();
    endtask

    task automatic partial(input int k, input logic [2:0] bits);
        for (int i = 0; i < k; i++) begin
            clock_dr = 1'b1;
            shift_dr = 1'b1;
            TDI      = bits[i];
            m_sr     = {bits[i], m_sr[DRW-1:1]};
            cycle();
        end
        clock_dr = 1'b0;
        shift_dr = 1'b0;
    endtask

    // Idle cycles with shift_dr toggling but clock_dr low: the register must not move.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            clock_dr = 1'b0;
            shift_dr = 1'($urandom);
            TDI      = 1'($urandom);
            cycle();
        end
        shift_dr = 1'b0;
    endtask

    typedef struct {
        logic [1:0]     op;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
        int             d;
        logic [DW-1:0]  rd;
        int             ncyc;
        logic [DRW-1:0] cap;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DRW-1:0] cap;
        int n, r, k;

        tbl[0] = '{2'b10, 8'h12, 32'hDEADBEEF, 2, 32'h0,        3, {2'b00, 8'h12, 32'h00000000}};
        tbl[1] = '{2'b01, 8'h34, 32'h0,        1, 32'hCAFEF00D, 2, {2'b00, 8'h34, 32'hCAFEF00D}};
        tbl[2] = '{2'b01, 8'h56, 32'h0,        9, 32'h11111111, 4, {2'b11, 8'h56, 32'hCAFEF00D}};
        tbl[3] = '{2'b11, 8'h00, 32'h0,        0, 32'h0,        0, {2'b00, 8'h56, 32'hCAFEF00D}};
        tbl[4] = '{2'b01, 8'h00, 32'h0,        0, 32'h00000001, 1, {2'b00, 8'h00, 32'h00000001}};
        tbl[5] = '{2'b01, 8'hFF, 32'h0,        3, 32'hFFFFFFFF, 4, {2'b00, 8'hFF, 32'hFFFFFFFF}};
        tbl[6] = '{2'b00, 8'h77, 32'h5,        0, 32'h0,        0, {2'b00, 8'hFF, 32'hFFFFFFFF}};
        tbl[7] = '{2'b01, 8'h20, 32'h0,        5, 32'h12345678, 4, {2'b11, 8'h20, 32'hFFFFFFFF}};
        tbl[8] = '{2'b10, 8'h21, 32'hA5A5A5A5, 0, 32'h0,        1, {2'b00, 8'h21, 32'hFFFFFFFF}};

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();

        // Reset state
        #2 TRST = 1'b0;
        #1 check("reset_out", {s_data_out_dr, bus_req, bus_we, bus_addr, bus_wdata}, '0);
        repeat (3) cycle();
        TRST = 1'b1;
        idle(2);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            mem[tbl[i].addr] = tbl[i].rd;
            force_delay = tbl[i].d;
            scan(cmd(tbl[i].op, tbl[i].addr, tbl[i].data), 1'b1, cap);
            if (tbl[i].ncyc > 0) begin
                check("tbl_bus", {bus_req, bus_we, bus_addr}, {1'b1, tbl[i].op == 2'b10, tbl[i].addr});
                if (tbl[i].op == 2'b10) check("tbl_wdata", bus_wdata, tbl[i].data);
            end
            n = 0;
            for (int j = 0; j < 12; j++) begin
                if (bus_req) n++;
                cycle();
            end
            check("tbl_cycles", n, tbl[i].ncyc);
            scan('0, 1'b0, cap);
            check("tbl_capture", cap, tbl[i].cap);
        end

        // Capture on the completion edge still reports BUSY
        force_delay = 0;
        mem[8'h10] = 32'h600DF00D;
        scan(cmd(2'b01, 8'h10, '0), 1'b1, cap);
        scan('0, 1'b0, cap);
        check("cap_on_done", cap, {2'b01, 8'h10, 32'hFFFFFFFF});
        scan('0, 1'b0, cap);
        check("cap_after_done", cap, {2'b00, 8'h10, 32'h600DF00D});

        // Overrun: a WRITE assembled by a short shift during REQ is dropped
        force_delay = 3;
        scan(cmd(2'b10, 8'h40, 32'h11111111), 1'b1, cap);
        partial(2, 3'b010);
        do_update();
        check("ovr_bus", {bus_req, bus_we, bus_addr, bus_wdata}, {1'b1, 1'b1, 8'h40, 32'h11111111});
        idle(3);
        scan('0, 1'b0, cap);
        check("ovr_capture", cap, {2'b10, 8'h40, 32'h600DF00D});
        scan(cmd(2'b11, 8'h00, '0), 1'b1, cap);
        scan('0, 1'b0, cap);
        check("clr_capture", cap, {2'b00, 8'h40, 32'h600DF00D});

        // Update on the ack edge is an overrun; the read itself still lands
        force_delay = 2;
        mem[8'h50] = 32'h0BADCAFE;
        scan(cmd(2'b01, 8'h50, '0), 1'b1, cap);
        cycle();
        cycle();
        do_update();
        idle(2);
        scan('0, 1'b0, cap);
        check("ack_edge_ovr", cap, {2'b10, 8'h50, 32'h0BADCAFE});
        scan(cmd(2'b11, 8'h00, '0), 1'b1, cap);

        // Random traffic
        force_delay = -1;
        for (int ev = 0; ev < 200; ev++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                scan(cmd(2'($urandom), 8'($urandom), $urandom), $urandom_range(0, 4) != 0, cap);
            end else if (r < 7) begin
                do_update();
            end else if (r < 9) begin
                k = $urandom_range(1, 3);
                partial(k, 3'($urandom));
                do_update();
            end else begin
                scan({10'($urandom), 32'($urandom)}, 1'b0, cap);
            end
            idle($urandom_range(0, 4));
        end
        idle(8);

        // Reset in the middle of a request
        force_delay = 9;
        scan(cmd(2'b01, 8'h77, '0), 1'b1, cap);
        cycle();
        TRST = 1'b0;
        model_reset();
        #1 check("trst_req", bus_req, 1'b0);
        check("trst_out", {s_data_out_dr, bus_we, bus_addr, bus_wdata}, '0);
        cycle();
        cycle();
        TRST = 1'b1;
        idle(2);
        scan('0, 1'b0, cap);
        check("trst_capture", cap, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
